// File: rtl/sync_ptr_gray_if.sv
// Pointer-synchroniser bundle: the foreign-domain Gray pointer and clear going in,
// the synchronised pointer views and status flags coming out.
interface sync_ptr_gray_if #(
    parameter int ADDR = 5
);
    logic [ADDR:0] ptr_gray;
    logic          err_clr;
    logic [ADDR:0] ptr_gray_sync;
    logic [ADDR:0] ptr_bin_sync;
    logic [ADDR:0] ptr_delta;
    logic          ptr_changed;
    logic          sync_rdy;
    logic          gray_err;

    modport master (
        output ptr_gray,
        output err_clr,
        input  ptr_gray_sync,
        input  ptr_bin_sync,
        input  ptr_delta,
        input  ptr_changed,
        input  sync_rdy,
        input  gray_err
    );

    modport slave (
        input  ptr_gray,
        input  err_clr,
        output ptr_gray_sync,
        output ptr_bin_sync,
        output ptr_delta,
        output ptr_changed,
        output sync_rdy,
        output gray_err
    );
endinterface

// File: rtl/sync_ptr_gray.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer, with registered binary
// view, per-cycle advance, warm-up flag and sticky illegal-step detection.
module sync_ptr_gray #(
    parameter int ADDR   = 5,
    parameter int STAGES = 2,
    parameter int CHECK  = 1
) (
    input  logic           clk,
    input  logic           reset_b,
    sync_ptr_gray_if.slave bus
);
    localparam int W  = ADDR + 1;
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STAGES + 1);

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $fatal(1, "sync_ptr_gray: STAGES must be in 2..4");
        end
    endgenerate

    // Only stage 0 samples the foreign-domain pointer; the chain carries no logic.
    (* async_reg = "true" *) logic [W-1:0] sync_stage [STAGES];

    logic [W-1:0]  gray_sync;
    logic [W-1:0]  prev_gray;
    logic [CW-1:0] warm_cnt;
    logic          sync_rdy;

    logic [W-1:0]  bin_q;
    logic [W-1:0]  delta_q;
    logic          changed_q;
    logic          err_q;

    logic [W-1:0]  cur_bin;
    logic [W-1:0]  prev_bin;
    logic [W-1:0]  step_bits;
    logic          multi_bit;
    logic          bad_step;
    logic          err_next;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // NOTE: the synchroniser array is cleared on reset like every other register,
    // so the first post-reset comparison is against a known all-zero history.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its
            // predecessor's old value, which is what makes this a shift chain.
            sync_stage[0] <= bus.ptr_gray;
            for (int i = 1; i < STAGES; i++) begin
                sync_stage[i] <= sync_stage[i-1];
            end
        end
    end

    assign gray_sync = sync_stage[STAGES-1];
    assign sync_rdy  = (warm_cnt == CNT_MAX);

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned and infers a latch.
    always_comb begin
        cur_bin   = g2b(gray_sync);
        prev_bin  = g2b(prev_gray);
        step_bits = gray_sync ^ prev_gray;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi_bit = |(step_bits & (step_bits - W'(1)));
        bad_step  = (CHECK != 0) && sync_rdy && multi_bit;
        err_next  = bad_step || (err_q && !bus.err_clr);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            warm_cnt  <= '0;
            prev_gray <= '0;
            bin_q     <= '0;
            delta_q   <= '0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (warm_cnt != CNT_MAX) begin
                warm_cnt <= warm_cnt + CW'(1);
            end
            prev_gray <= gray_sync;
            bin_q     <= cur_bin;
            delta_q   <= cur_bin - prev_bin;
            changed_q <= (gray_sync != prev_gray) && sync_rdy;
            err_q     <= err_next;
        end
    end

    assign bus.ptr_gray_sync = gray_sync;
    assign bus.ptr_bin_sync  = bin_q;
    assign bus.ptr_delta     = delta_q;
    assign bus.ptr_changed   = changed_q;
    assign bus.sync_rdy      = sync_rdy;
    assign bus.gray_err      = err_q;
endmodule

// File: tb/tb_sync_ptr_gray.sv
// Bench for sync_ptr_gray: two instances (checker on/off) fed identical pointers;
// expected change events are queued at stimulus time and popped by per-instance monitors.
module tb_sync_ptr_gray;
    localparam int ADDR   = 4;
    localparam int W      = ADDR + 1;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [W-1:0] delta;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_b;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    sync_ptr_gray_if #(.ADDR(ADDR)) bus_a ();
    sync_ptr_gray_if #(.ADDR(ADDR)) bus_b ();

    sync_ptr_gray #(.ADDR(ADDR), .STAGES(STAGES), .CHECK(1)) dut_a (
        .clk    (clk),
        .reset_b(reset_b),
        .bus    (bus_a.slave)
    );

    sync_ptr_gray #(.ADDR(ADDR), .STAGES(STAGES), .CHECK(0)) dut_b (
        .clk    (clk),
        .reset_b(reset_b),
        .bus    (bus_b.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] to_gray(input int b);
        return W'(b ^ (b >> 1));
    endfunction

    task automatic drive_clr(input logic clr);
        bus_a.err_clr = clr;
        bus_b.err_clr = clr;
    endtask

    // Drive a new pointer; when an output event is expected, queue it for both monitors.
    task automatic step(input logic [W-1:0] g, input logic [W-1:0] e_bin, input logic [W-1:0] e_delta,
                        input logic e_err_a, input logic e_err_b, input bit expect_evt);
        exp_t e;
        bus_a.ptr_gray = g;
        bus_b.ptr_gray = g;
        if (expect_evt) begin
            e.bin   = e_bin;
            e.delta = e_delta;
            e.err   = e_err_a;
            q_a.push_back(e);
            e.err   = e_err_b;
            q_b.push_back(e);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] sync, input logic [W-1:0] bin,
                             input logic [W-1:0] delta, input logic chg, input logic rdy,
                             input logic err_a, input logic err_b);
        check({tag, "_sync"},  32'(bus_a.ptr_gray_sync), 32'(sync));
        check({tag, "_bin"},   32'(bus_a.ptr_bin_sync),  32'(bin));
        check({tag, "_delta"}, 32'(bus_a.ptr_delta),     32'(delta));
        check({tag, "_chg"},   32'(bus_a.ptr_changed),   32'(chg));
        check({tag, "_rdy"},   32'(bus_a.sync_rdy),      32'(rdy));
        check({tag, "_err_a"}, 32'(bus_a.gray_err),      32'(err_a));
        check({tag, "_bin_b"}, 32'(bus_b.ptr_bin_sync),  32'(bin));
        check({tag, "_err_b"}, 32'(bus_b.gray_err),      32'(err_b));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_b === 1'b1 && bus_a.ptr_changed === 1'b1) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_unexpected_change: bin=%0d delta=%0d, expected no event", bus_a.ptr_bin_sync, bus_a.ptr_delta);
            end else begin
                e = q_a.pop_front();
                check("a_evt_bin",   32'(bus_a.ptr_bin_sync), 32'(e.bin));
                check("a_evt_delta", 32'(bus_a.ptr_delta),    32'(e.delta));
                check("a_evt_err",   32'(bus_a.gray_err),     32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_b === 1'b1 && bus_b.ptr_changed === 1'b1) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_unexpected_change: bin=%0d delta=%0d, expected no event", bus_b.ptr_bin_sync, bus_b.ptr_delta);
            end else begin
                e = q_b.pop_front();
                check("b_evt_bin",   32'(bus_b.ptr_bin_sync), 32'(e.bin));
                check("b_evt_delta", 32'(bus_b.ptr_delta),    32'(e.delta));
                check("b_evt_err",   32'(bus_b.gray_err),     32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_b = 1'b0;
        drive_clr(1'b0);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check_all("reset", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Warm-up: ready exactly STAGES+1 edges after release.
        reset_b = 1'b1;
        tick(); check("rdy_e1", 32'(bus_a.sync_rdy), 0);
        tick(); check("rdy_e2", 32'(bus_a.sync_rdy), 0);
        tick(); check_all("rdy_e3", '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // Single step 0 -> 1 with exact latency.
        step(5'b00001, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1);
        tick(); check("step1_sync_e1", 32'(bus_a.ptr_gray_sync), 0);
        tick(); check("step1_sync_e2", 32'(bus_a.ptr_gray_sync), 1);
                check("step1_bin_e2",  32'(bus_a.ptr_bin_sync), 0);
        tick(); check_all("step1_e3", 5'b00001, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); check_all("step1_e4", 5'b00001, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back legal steps up to the top of the range.
        for (int b = 2; b < 32; b++) begin
            step(to_gray(b), W'(b), 5'd1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        repeat (4) tick();
        check_all("top", 5'b10000, 5'd31, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Wrap from 31 to 0.
        step(5'b00000, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check_all("wrap", 5'b00000, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();

        // Illegal two-bit step: data still reported, only the checked instance flags.
        step(5'b00011, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        check_all("illegal", 5'b00011, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        check_all("illegal_hold", 5'b00011, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        drive_clr(1'b1);
        tick();
        drive_clr(1'b0);
        check("err_cleared", 32'(bus_a.gray_err), 0);
        tick();
        check("err_stays_clear", 32'(bus_a.gray_err), 0);

        // Reverse illegal step with clear asserted on the detecting edge: set wins.
        step(5'b00000, 5'd0, 5'd30, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        drive_clr(1'b1);
        tick();
        drive_clr(1'b0);
        check_all("set_wins", 5'b00000, 5'd0, 5'd30, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("set_wins_sticky", 32'(bus_a.gray_err), 1);

        // Asynchronous reset while a new pointer is inside the chain.
        step(5'b00110, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_b = 1'b0;
        #1;
        check_all("async_rst", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset_b = 1'b1;
        tick(); check("rst_rel_e1_rdy", 32'(bus_a.sync_rdy), 0);
        tick(); check("rst_rel_e2_sync", 32'(bus_a.ptr_gray_sync), 32'(5'b00110));
                check("rst_rel_e2_bin",  32'(bus_a.ptr_bin_sync), 0);
        tick(); check_all("rst_rel_e3", 5'b00110, 5'd4, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check_all("rst_rel_settled", 5'b00110, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        check("q_a_drained", 32'(q_a.size()), 0);
        check("q_b_drained", 32'(q_b.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
